uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; the bit period in clocks is round(CLK_HZ/BAUD) = 10417.
REQ-003 Port clk, input, 1 bit, single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 Port RX, input, 1 bit, asynchronous UART serial line; idle high; 8N1 framing, LSB first.
REQ-006 Port owData, output, 8 bits, last correctly framed received byte.
REQ-007 Port owSTART, output, 1 bit, one-cycle pulse marking a validated start bit.
REQ-008 Port oRate, output, 2 bits, rate code selected by received ASCII commands.
REQ-009 Port owClk1s, output, 1 bit, free-running 1 Hz square wave, 50% duty.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer; all receiver logic uses only the synchronized value.
REQ-011 The receiver SHALL be a state machine with states IDLE, START, DATA and STOP.
REQ-012 In IDLE, a synchronized high-to-low transition SHALL enter START and clear the bit-timing counter.
REQ-013 In START, at half a bit period (5208 clocks), RX low SHALL validate the start bit, pulse owSTART for exactly one clock, and enter DATA; RX high SHALL return to IDLE with no pulse (glitch rejection).
REQ-014 In DATA, RX SHALL be sampled every full bit period (10417 clocks) after start-bit validation, 8 samples total, shifted in LSB first.
REQ-015 In STOP, RX SHALL be sampled one bit period after the 8th data sample.
REQ-016 If the STOP sample is high, owData SHALL load the shifted byte on that clock; if low (framing error), owData SHALL stay unchanged and no command is decoded.
REQ-017 STOP SHALL always return to IDLE on the clock after the sample; a new start edge is accepted from the next clock, so back-to-back frames with no idle gap are received.
REQ-018 Command decode SHALL run on the clock owData loads: byte 0x30..0x33 ('0'..'3') sets oRate to byte[1:0]; all other bytes leave oRate unchanged.
REQ-019 owClk1s SHALL toggle every CLK_HZ/2 = 50,000,000 clocks, counting from reset, independent of UART activity.
REQ-020 The bit-timing counter SHALL be wide enough for 10417 with no wrap during a frame; the 1 Hz counter SHALL be 26 bits.

Reset
REQ-021 While reset is high: state IDLE, synchronizer flops 1, shift register 0, owData 8'h00, owSTART 0, oRate 2'b00, owClk1s 0, all counters 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no owData or oRate update; after release the receiver waits for a new falling edge in IDLE.

Verification
REQ-023 Reset release, RX held high for 1 ms -> owData 0x00, oRate 0, owSTART never high.
REQ-024 Frame 0x34 ('4') at 104166 ns/bit -> one owSTART pulse about 52 us after the falling edge; owData becomes 0x34 in the stop bit; oRate stays 0.
REQ-025 Back-to-back frames 0x4D, 0x35, 0x46, 0x34, 0x3F with no idle gap -> owData steps through each value in order, five owSTART pulses, oRate stays 0.
REQ-026 Frame 0x32 ('2'), then 0x31 ('1') -> oRate becomes 2, then 1; frame 0x33 -> oRate becomes 3.
REQ-027 Stop bit driven low for frame 0x31 -> owData and oRate unchanged; a 2 us low glitch on idle RX -> no owSTART pulse.
REQ-028 With reset released at t0 -> owClk1s rises at t0 + 0.5 s, falls at t0 + 1.0 s; reset mid-frame -> no owData update.

Source files
------------

// File: rtl/uart_top.sv
// uart_top: 8N1 UART receiver with ASCII rate-command decode and a 1 Hz tick.
//   clk      - system clock, all state on rising edge
//   reset    - asynchronous active-high reset
//   RX       - asynchronous serial input, idle high, LSB first
//   owData   - last correctly framed received byte
//   owSTART  - one-clock pulse when a start bit is validated
//   oRate    - rate code set by received '0'..'3'
//   owClk1s  - free-running 1 Hz square wave, 50% duty
module uart_top #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] owData,
  output logic       owSTART,
  output logic [1:0] oRate,
  output logic       owClk1s
);

  localparam int unsigned BIT_CLKS  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned SEC_HALF  = CLK_HZ / 2;
  localparam int unsigned CW        = $clog2(BIT_CLKS + 1);

  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CLKS - 1);
  localparam logic [25:0]   SEC_M1  = 26'(SEC_HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          start_n;
  logic [1:0]    rate_n;
  logic [25:0]   sec_cnt;

  // Two synchronizer flops plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      owData  <= '0;
      owSTART <= 1'b0;
      oRate   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      bit_idx <= idx_n;
      shift   <= shift_n;
      owData  <= data_n;
      owSTART <= start_n;
      oRate   <= rate_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt + CW'(1);
    idx_n   = bit_idx;
    shift_n = shift;
    data_n  = owData;
    start_n = 1'b0;
    rate_n  = oRate;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) state_n = START;
      end
      START: begin
        if (bit_cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_sync) begin
            start_n = 1'b1;
            idx_n   = '0;
            state_n = DATA;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_cnt == BIT_M1) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[7:1]};
          idx_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == BIT_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_sync) begin
            data_n = shift;
            if (shift[7:2] == 6'b001100) rate_n = shift[1:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt <= '0;
      owClk1s <= 1'b0;
    end else if (sec_cnt == SEC_M1) begin
      sec_cnt <= '0;
      owClk1s <= ~owClk1s;
    end else begin
      sec_cnt <= sec_cnt + 26'd1;
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed bench for uart_top with scaled clock/baud
// (8 clocks per bit, 1 Hz output toggles every 1000 clocks).
module tb_uart_top;

  localparam int BIT      = 8;
  localparam int HALF     = 4;
  localparam int HALF_SEC = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX;
  logic [7:0] owData;
  logic       owSTART;
  logic [1:0] oRate;
  logic       owClk1s;

  int errors = 0;
  int checks = 0;

  uart_top #(.CLK_HZ(2000), .BAUD(250)) dut (
    .clk(clk), .reset(reset), .RX(RX), .owData(owData),
    .owSTART(owSTART), .oRate(oRate), .owClk1s(owClk1s)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   start_cnt = 0;
  int   start_wide = 0;
  int   last_start_cyc = -1;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  logic prev_start = 1'b0;
  logic prev_clk1s = 1'b0;
  int   edge_cyc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (owSTART) begin
      start_cnt      = start_cnt + 1;
      last_start_cyc = cyc;
      if (prev_start) start_wide = start_wide + 1;
    end
    if (owClk1s && !prev_clk1s && rise_cyc < 0) rise_cyc = cyc;
    if (!owClk1s && prev_clk1s && fall_cyc < 0) fall_cyc = cyc;
    prev_start = owSTART;
    prev_clk1s = owClk1s;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      if (i == 0) edge_cyc = cyc;
      repeat (BIT) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic [1:0] exp_rate;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int s0;
    vecs[0]  = '{8'h34, 1'b1, 10, 8'h34, 2'd0};
    vecs[1]  = '{8'h4D, 1'b1, 10, 8'h4D, 2'd0};
    vecs[2]  = '{8'h35, 1'b1, 0,  8'h35, 2'd0};
    vecs[3]  = '{8'h46, 1'b1, 0,  8'h46, 2'd0};
    vecs[4]  = '{8'h34, 1'b1, 0,  8'h34, 2'd0};
    vecs[5]  = '{8'h3F, 1'b1, 0,  8'h3F, 2'd0};
    vecs[6]  = '{8'h32, 1'b1, 10, 8'h32, 2'd2};
    vecs[7]  = '{8'h31, 1'b1, 0,  8'h31, 2'd1};
    vecs[8]  = '{8'h33, 1'b1, 0,  8'h33, 2'd3};
    vecs[9]  = '{8'h31, 1'b0, 0,  8'h33, 2'd3};
    vecs[10] = '{8'h30, 1'b1, 10, 8'h30, 2'd0};
    vecs[11] = '{8'h41, 1'b1, 0,  8'h41, 2'd0};

    reset = 1'b1;
    RX    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data",  owData, 8'h00);
    check("reset_rate",  oRate, 0);
    check("reset_start", owSTART, 0);
    check("reset_clk1s", owClk1s, 0);
    reset = 1'b0;

    // Idle line for two half-seconds: no activity, 1 Hz edges at 1000/2000.
    while (cyc < 2*HALF_SEC + 5) @(negedge clk);
    check("idle_data",   owData, 8'h00);
    check("idle_rate",   oRate, 0);
    check("idle_starts", start_cnt, 0);
    check("clk1s_rise",  rise_cyc, HALF_SEC);
    check("clk1s_fall",  fall_cyc, 2*HALF_SEC);

    for (int v = 0; v < 12; v++) begin
      RX = 1'b1;
      repeat (vecs[v].gap) @(negedge clk);
      s0 = start_cnt;
      send_frame(vecs[v].tx, vecs[v].stop);
      check($sformatf("v%0d_data", v), owData, vecs[v].exp_data);
      check($sformatf("v%0d_rate", v), oRate, vecs[v].exp_rate);
      check($sformatf("v%0d_starts", v), start_cnt - s0, 1);
      check($sformatf("v%0d_start_lat", v), last_start_cyc - edge_cyc, HALF + 3);
    end

    // Short low glitch on idle line must not validate a start bit.
    RX = 1'b1;
    repeat (20) @(negedge clk);
    s0 = start_cnt;
    RX = 1'b0;
    repeat (2) @(negedge clk);
    RX = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_starts", start_cnt - s0, 0);
    check("glitch_data",   owData, 8'h41);

    // Reset in the middle of frame 0x33: nothing from that frame lands.
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
    repeat (2*BIT) @(negedge clk);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_clk1s", owClk1s, 0);
    reset = 1'b0;
    RX = 1'b1;
    repeat (12*BIT) @(negedge clk);
    check("midrst_data", owData, 8'h00);
    check("midrst_rate", oRate, 0);
    send_frame(8'h32, 1'b1);
    check("post_rst_data", owData, 8'h32);
    check("post_rst_rate", oRate, 2);
    RX = 1'b1;
    repeat (4) @(negedge clk);

    check("start_width", start_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
